// File: rtl/pla_sweep_pkg.sv
// Shared types and helpers for the PLA sweep signer.
// Holds the sweep FSM state type, the default MISR constants and the MISR
// next-state function used by the signature register.
package pla_sweep_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSweep,
    StDrain,
    StDone
  } state_e;

  localparam logic [15:0] DefaultSigPoly = 16'h1021;
  localparam logic [15:0] DefaultSigSeed = 16'hFFFF;

  // Widest signature misr_step can handle; narrower registers are zero-extended.
  localparam int unsigned MaxSigW = 32;

  // One Galois MISR step on a width-bit register: shift left, and XOR in the
  // polynomial when the outgoing MSB differs from the incoming bit.
  function automatic logic [MaxSigW-1:0] misr_step(input logic [MaxSigW-1:0] sig,
                                                   input logic               din,
                                                   input logic [MaxSigW-1:0] poly,
                                                   input int unsigned        width);
    logic [MaxSigW-1:0] mask;
    logic               fb;
    logic [MaxSigW-1:0] nxt;
    mask = {MaxSigW{1'b1}} >> (MaxSigW - width);
    fb   = sig[width-1] ^ din;
    nxt  = (sig << 1) ^ (fb ? poly : '0);
    return nxt & mask;
  endfunction

endpackage

// File: rtl/pla_misr.sv
// Signature register for the PLA sweep signer.
// Ports: clk/rst_n (async active-low reset to SIG_SEED), load (reseed, wins
// over en), en (absorb din this cycle), din (response bit), sig (signature).
module pla_misr
  import pla_sweep_pkg::*;
#(
  parameter int unsigned      SIG_W    = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(DefaultSigPoly),
  parameter logic [SIG_W-1:0] SIG_SEED = SIG_W'(DefaultSigSeed)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic             din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;

  always_comb begin
    sig_d = SIG_W'(misr_step(MaxSigW'(sig_q), din, MaxSigW'(SIG_POLY), SIG_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= SIG_SEED;
    end else if (load) begin
      sig_q <= SIG_SEED;
    end else if (en) begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/pla_sweep_signer.sv
// Exhaustive stimulus/response wrapper around a single-output PLA netlist.
// Drives all 2^N_IN vectors in ascending order, then counts the ones in the
// response and compacts it into a MISR signature.
// Ports: clk, rst_n (async active-low), start (pulse, honoured in IDLE/DONE),
// x_out/x_valid (vector to the netlist), y_in (netlist output, LATENCY cycles
// behind x_out), busy (SWEEP/DRAIN), done (held until next start),
// ones_count, signature.
module pla_sweep_signer
  import pla_sweep_pkg::*;
#(
  parameter int unsigned      N_IN     = 8,
  parameter int unsigned      LATENCY  = 0,
  parameter int unsigned      SIG_W    = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(DefaultSigPoly),
  parameter logic [SIG_W-1:0] SIG_SEED = SIG_W'(DefaultSigSeed)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [N_IN-1:0]  x_out,
  output logic             x_valid,
  input  logic             y_in,
  output logic             busy,
  output logic             done,
  output logic [N_IN:0]    ones_count,
  output logic [SIG_W-1:0] signature
);

  localparam int unsigned CntW   = N_IN + 1;
  localparam int unsigned DrainW = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  state_e            state_q;
  logic [N_IN-1:0]   x_q;
  logic              x_valid_q;
  logic              busy_q;
  logic              done_q;
  logic [CntW-1:0]   ones_q;
  logic [DrainW-1:0] drain_q;

  logic sample_en;
  logic sample_bit;
  logic launch;

  assign launch = start && ((state_q == StIdle) || (state_q == StDone));

  // A sample is due exactly when the matching x_valid has travelled through
  // the same number of stages as the netlist pipeline.
  if (LATENCY == 0) begin : g_no_dly
    assign sample_en = x_valid_q;
  end else begin : g_dly
    logic [LATENCY-1:0] dly_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dly_q <= '0;
      end else begin
        dly_q <= LATENCY'({dly_q, x_valid_q});
      end
    end
    assign sample_en = dly_q[LATENCY-1];
  end

  // Gate y_in so an undriven or X response outside sample slots never reaches state.
  assign sample_bit = sample_en & y_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      x_q       <= '0;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ones_q    <= '0;
      drain_q   <= '0;
    end else begin
      if (sample_en) begin
        ones_q <= ones_q + CntW'(sample_bit);
      end
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q   <= StSweep;
            x_q       <= '0;
            x_valid_q <= 1'b1;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            ones_q    <= '0;
          end
        end
        StSweep: begin
          if (x_q == '1) begin
            x_q       <= '0;
            x_valid_q <= 1'b0;
            drain_q   <= '0;
            if (LATENCY == 0) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= StDrain;
            end
          end else begin
            x_q <= x_q + N_IN'(1);
          end
        end
        StDrain: begin
          // The last sample is absorbed on the same edge that leaves DRAIN.
          if (drain_q == DrainW'(LATENCY - 1)) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + DrainW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  pla_misr #(
    .SIG_W   (SIG_W),
    .SIG_POLY(SIG_POLY),
    .SIG_SEED(SIG_SEED)
  ) u_misr (
    .clk  (clk),
    .rst_n(rst_n),
    .load (launch),
    .en   (sample_en),
    .din  (sample_bit),
    .sig  (signature)
  );

  assign x_out      = x_q;
  assign x_valid    = x_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign ones_count = ones_q;

endmodule

// File: tb/tb_pla_sweep_signer.sv
module tb_pla_sweep_signer;
  import pla_sweep_pkg::*;

  typedef struct {
    int          ones;
    logic [15:0] sig;
    longint      cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic [255:0] tt;
  logic junk = 1'b0;
  longint cyc = 0;

  int tests = 0;
  int fails = 0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  // A: LATENCY 0, default seed.  B: LATENCY 3.  C: LATENCY 0, seed 0.
  logic [7:0]  xa_out, xb_out, xc_out;
  logic        xa_valid, xb_valid, xc_valid;
  logic        ya, yb, yc;
  logic        busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic [8:0]  ones_a, ones_b, ones_c;
  logic [15:0] sig_a, sig_b, sig_c;
  logic        p0, p1, p2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) junk <= 1'($urandom());

  assign ya = xa_valid ? tt[xa_out] : junk;
  assign yc = xc_valid ? tt[xc_out] : junk;
  always @(posedge clk) begin
    p0 <= xb_valid ? tt[xb_out] : junk;
    p1 <= p0;
    p2 <= p1;
  end
  assign yb = p2;

  pla_sweep_signer dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .x_out(xa_out), .x_valid(xa_valid),
    .y_in(ya), .busy(busy_a), .done(done_a), .ones_count(ones_a), .signature(sig_a)
  );

  pla_sweep_signer #(.LATENCY(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .x_out(xb_out), .x_valid(xb_valid),
    .y_in(yb), .busy(busy_b), .done(done_b), .ones_count(ones_b), .signature(sig_b)
  );

  pla_sweep_signer #(.SIG_SEED(16'h0000)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start), .x_out(xc_out), .x_valid(xc_valid),
    .y_in(yc), .busy(busy_c), .done(done_c), .ones_count(ones_c), .signature(sig_c)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk the truth table in vector order and divide the response
  // stream by the feedback polynomial, one bit at a time.
  function automatic void ref_model(input logic [255:0] t, input logic [15:0] seed,
                                    output int ones, output logic [15:0] sig);
    ones = 0;
    sig  = seed;
    for (int v = 0; v < 256; v++) begin
      int msb;
      int y;
      y    = int'(t[v]);
      ones = ones + y;
      msb  = int'(sig >> 15);
      sig  = 16'((int'(sig) * 2) % 65536);
      if ((msb ^ y) != 0) sig = sig ^ 16'h1021;
    end
  endfunction

  // Monitors: scoreboard comparison whenever a DUT raises done.
  logic pa = 1'b0, pb = 1'b0, pc = 1'b0;
  int   vcnt = 0;
  bit   seq_ok = 1'b1;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      pa = 1'b0; vcnt = 0; seq_ok = 1'b1;
    end else begin
      if (xa_valid) begin
        if (int'(xa_out) != (vcnt % 256)) seq_ok = 1'b0;
        vcnt++;
      end
      if (done_a && !pa) begin
        if (qa.size() == 0) begin
          tests++; fails++;
          $display("FAIL a_unexpected_done: got done=1, expected no pending sweep");
        end else begin
          exp_t e;
          e = qa.pop_front();
          chk("a_ones", ones_a, e.ones);
          chk("a_sig", sig_a, e.sig);
          chk("a_done_cycle", cyc, e.cyc);
          chk("a_busy_at_done", busy_a, 0);
          chk("a_x_sequence_ok", seq_ok, 1);
          chk("a_valid_cycles", vcnt, 256);
        end
        vcnt = 0; seq_ok = 1'b1;
      end
      pa = done_a;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst_n) pb = 1'b0;
    else begin
      if (done_b && !pb) begin
        if (qb.size() == 0) begin
          tests++; fails++;
          $display("FAIL b_unexpected_done: got done=1, expected no pending sweep");
        end else begin
          exp_t e;
          e = qb.pop_front();
          chk("b_ones", ones_b, e.ones);
          chk("b_sig", sig_b, e.sig);
          chk("b_done_cycle", cyc, e.cyc);
          chk("b_busy_at_done", busy_b, 0);
        end
      end
      pb = done_b;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst_n) pc = 1'b0;
    else begin
      if (done_c && !pc) begin
        if (qc.size() == 0) begin
          tests++; fails++;
          $display("FAIL c_unexpected_done: got done=1, expected no pending sweep");
        end else begin
          exp_t e;
          e = qc.pop_front();
          chk("c_ones", ones_c, e.ones);
          chk("c_sig", sig_c, e.sig);
          chk("c_done_cycle", cyc, e.cyc);
        end
      end
      pc = done_c;
    end
  end

  // Pulse start and queue the expected results. s is the cycle index of the
  // edge that samples start; done is visible 2^N_IN + LATENCY edges later.
  task automatic issue_run(input logic [255:0] t, input bit push, output longint s,
                           output int ones, output logic [15:0] sf);
    logic [15:0] s0;
    int          o0;
    ref_model(t, 16'hFFFF, ones, sf);
    ref_model(t, 16'h0000, o0, s0);
    @(negedge clk);
    tt    = t;
    start = 1'b1;
    @(posedge clk);
    #1;
    s     = cyc;
    start = 1'b0;
    if (push) begin
      qa.push_back('{ones, sf, s + 256});
      qb.push_back('{ones, sf, s + 259});
      qc.push_back('{o0, s0, s + 256});
    end
    chk("a_busy_after_start", busy_a, 1);
    chk("a_done_after_start", done_a, 0);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && (qa.size() + qb.size() + qc.size()) != 0; i++)
      @(negedge clk);
    chk("pending_results_after_timeout", qa.size() + qb.size() + qc.size(), 0);
  endtask

  task automatic hold_check(input int ones, input logic [15:0] sf);
    repeat (4) @(negedge clk);
    chk("a_done_held", done_a, 1);
    chk("a_ones_held", ones_a, ones);
    chk("a_sig_held", sig_a, sf);
    chk("b_sig_held", sig_b, sf);
  endtask

  task automatic start_pulse_at(input longint c);
    while (cyc < c - 1) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic full_run(input logic [255:0] t);
    longint      s;
    int          ones;
    logic [15:0] sf;
    issue_run(t, 1'b1, s, ones, sf);
    wait_idle(400);
    hold_check(ones, sf);
  endtask

  initial begin
    logic [255:0] t;
    longint       s;
    int           ones;
    logic [15:0]  sf;

    rst_n = 1'b0;
    start = 1'b0;
    tt    = '0;
    repeat (3) @(negedge clk);
    chk("rst_x_out", xa_out, 0);
    chk("rst_x_valid", xa_valid, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_ones", ones_a, 0);
    chk("rst_sig_a", sig_a, 16'hFFFF);
    chk("rst_sig_b", sig_b, 16'hFFFF);
    chk("rst_sig_c", sig_c, 16'h0000);
    rst_n = 1'b1;

    // The package step function must agree with the bench's own arithmetic.
    for (int i = 0; i < 8; i++) begin
      logic [255:0] one_hot;
      logic [15:0]  seed, want;
      int           o;
      seed    = 16'($urandom());
      one_hot = '0;
      one_hot[255] = 1'($urandom());
      ref_model(one_hot, seed, o, want);
      for (int k = 0; k < 255; k++) seed = 16'(misr_step(32'(seed), 1'b0, 32'h1021, 16));
      seed = 16'(misr_step(32'(seed), one_hot[255], 32'h1021, 16));
      chk("misr_step_vs_model", seed, want);
    end

    t = '0;                full_run(t);
    t = '1;                full_run(t);
    t = {128{2'b10}};      full_run(t);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom();
      full_run(t);
    end

    // Starts during the sweep and on the DONE-transition edge are ignored.
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom();
    issue_run(t, 1'b1, s, ones, sf);
    start_pulse_at(s + 10);
    start_pulse_at(s + 200);
    start_pulse_at(s + 256);
    wait_idle(400);
    hold_check(ones, sf);
    chk("b_busy_after_ignored", busy_b, 0);
    // A start in DONE reruns the sweep with identical results.
    full_run(t);

    // Reset mid-sweep drops everything; the next sweep is complete.
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom();
    issue_run(t, 1'b0, s, ones, sf);
    while (cyc < s + 100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_x_out", xa_out, 0);
    chk("midrst_x_valid", xa_valid, 0);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_done", done_a, 0);
    chk("midrst_ones", ones_a, 0);
    chk("midrst_sig_a", sig_a, 16'hFFFF);
    chk("midrst_busy_b", busy_b, 0);
    chk("midrst_sig_c", sig_c, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    full_run(t);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
